// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: dual-port RAM array, occupancy count,
// full/empty/almost flags, sticky overflow/underflow and a registered read port.
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] ram_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;

  // Flags decode the registered count; the pointers never disambiguate full/empty.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Accept decisions, pointer/count update and error flag next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;

    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      rd_data_d  = ram_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh error outranks a same-cycle clear.
    if (wr_en & ~wr_acc) overflow_d  = 1'b1;
    if (rd_en & ~rd_acc) underflow_d = 1'b1;
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      ram_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int tests = 0;
  int fails = 0;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .reset_p(reset_p), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, outputs as plain variables.
  logic [7:0] m_q [$];
  logic [7:0] m_rd_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      m_q.delete();
      m_rd_data = 8'h00;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
    end else begin
      bit racc, wacc;
      racc = rd_en && (m_q.size() > 0);
      wacc = wr_en && ((m_q.size() < DEPTH) || racc);
      if (wr_en && !wacc)   m_ovf = 1'b1;
      else if (clr_err)     m_ovf = 1'b0;
      if (rd_en && !racc)   m_unf = 1'b1;
      else if (clr_err)     m_unf = 1'b0;
      m_valid = racc;
      if (racc) m_rd_data = m_q.pop_front();
      if (wacc) m_q.push_back(wr_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int n;
    n = m_q.size();
    chk("cmp_count",     32'(count),        32'(n));
    chk("cmp_full",      32'(full),         32'(n == DEPTH));
    chk("cmp_empty",     32'(empty),        32'(n == 0));
    chk("cmp_af",        32'(almost_full),  32'(n >= 14));
    chk("cmp_ae",        32'(almost_empty), 32'(n <= 2));
    chk("cmp_rd_valid",  32'(rd_valid),     32'(m_valid));
    chk("cmp_rd_data",   32'(rd_data),      32'(m_rd_data));
    chk("cmp_overflow",  32'(overflow),     32'(m_ovf));
    chk("cmp_underflow", 32'(underflow),    32'(m_unf));
  end

  // One clock of stimulus, applied after a falling edge; returns at the next falling edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    reset_p = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_count",    32'(count),        32'd0);
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_ae",       32'(almost_empty), 32'd1);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_rd_valid", 32'(rd_valid),     32'd0);
    chk("rst_rd_data",  32'(rd_data),      32'd0);
    reset_p = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 13) chk("af_at_13", 32'(almost_full), 32'd0);
      if (i == 14) chk("af_at_14", 32'(almost_full), 32'd1);
      if (i == 15) chk("full_at_15", 32'(full), 32'd0);
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full",  32'(full),  32'd1);

    // Rejected write while full.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_count", 32'(count),    32'd16);
    chk("ovf_set",   32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr",   32'(overflow), 32'd0);

    // Write and read together while full.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullrw_valid", 32'(rd_valid), 32'd1);
    chk("fullrw_data",  32'(rd_data),  32'h01);
    chk("fullrw_count", 32'(count),    32'd16);
    chk("fullrw_ovf",   32'(overflow), 32'd0);

    // Drain: 0x02..0x10 then 0x55; 0xAA must never appear.
    for (int i = 2; i <= 17; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data",  32'(rd_data),  (i == 17) ? 32'h55 : 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold",  32'(rd_data),  32'h55);

    // Read and write together while empty.
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("emptyrw_unf",   32'(underflow), 32'd1);
    chk("emptyrw_valid", 32'(rd_valid),  32'd0);
    chk("emptyrw_count", 32'(count),     32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("emptyrw_data",  32'(rd_data),   32'h33);
    chk("emptyrw_rv",    32'(rd_valid),  32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr",       32'(underflow), 32'd0);

    // Pointer wrap: prefill 4, then 40 write+read pairs at steady occupancy.
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
    for (int k = 4; k < 44; k++) begin
      if (k == 20) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_dip_count", 32'(count), 32'd3);
        step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
        chk("wrap_back_count", 32'(count), 32'd4);
      end else begin
        step(1'b1, 8'(8'h80 + k), 1'b1, 1'b0);
      end
      chk("wrap_count", 32'(count), 32'd4);
    end
    chk("wrap_last_data", 32'(rd_data), 32'h80 + 32'd39);

    // Asynchronous reset between edges with four words held.
    #3 reset_p = 1'b1;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    @(negedge clk);
    reset_p = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_unf",   32'(underflow), 32'd1);
    chk("post_rst_valid", 32'(rd_valid),  32'd0);

    step(1'b0, 8'h00, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
